fifo_stream_reader: RTL and testbench

- Downstream consumer of the team's synchronous FIFO, configured in normal (non-showahead) mode with 1-cycle read latency.
- Issues read requests to the FIFO and captures returned words in a small skid buffer.
- Presents the words on a valid/ready stream with packet framing (sop/eop every PKT_LEN beats).
- No combinational path from ready_i to fifo_rdreq_o, so the FIFO read side stays register-timed.

---
 rtl/fifo_stream_reader.sv | 105 ++++++++++
 tb/tb_fifo_stream_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//   Reads words from a synchronous FIFO (normal mode, 1-cycle read latency)
//   into a small skid buffer and presents them on a valid/ready stream with
//   packet framing (sop/eop every PKT_LEN beats).
//
//   The read decision uses only registered occupancy plus the registered
//   in-flight flag, so there is no combinational path from ready_i to
//   fifo_rdreq_o.
//
// Ports
//   clk_i        in   clock
//   arstn_i      in   asynchronous active-low reset
//   en_i         in   read enable (gates new reads only; buffer still drains)
//   fifo_q_i     in   FIFO read data, valid the cycle after fifo_rdreq_o
//   fifo_empty_i in   FIFO empty flag
//   fifo_rdreq_o out  FIFO read request
//   data_o       out  stream data (buffer head, registered)
//   valid_o      out  stream valid
//   ready_i      in   stream ready
//   sop_o        out  first beat of packet (qualified by valid_o)
//   eop_o        out  last beat of packet (qualified by valid_o)
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
   parameter int DWIDTH    = 8,
   parameter int BUF_DEPTH = 3,
   parameter int PKT_LEN   = 4
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              en_i,
   input  logic [DWIDTH-1:0] fifo_q_i,
   input  logic              fifo_empty_i,
   output logic              fifo_rdreq_o,
   output logic [DWIDTH-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              sop_o,
   output logic              eop_o
);

   localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int OW = $clog2(BUF_DEPTH + 1);

   // Entry 0 is always the head, so data_o comes straight from a flop.
   logic [BUF_DEPTH-1:0][DWIDTH-1:0] r_buf;
   logic [BUF_DEPTH-1:0][DWIDTH-1:0] w_buf_nxt;
   logic [OW-1:0]                    r_occ;
   logic                             r_inflight;
   logic [CW-1:0]                    r_cnt;

   logic          w_push;
   logic          w_pop;
   logic [OW-1:0] w_wr_idx;
   logic [OW:0]   w_pending;

   // Words already owned by this block: buffered plus the one on its way.
   assign w_pending = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight};

   // Reserving a slot for the in-flight word keeps occ+inflight <= BUF_DEPTH,
   // so a capture can never land on a full buffer.
   assign fifo_rdreq_o = arstn_i & en_i & ~fifo_empty_i &
                         (w_pending < (OW+1)'(BUF_DEPTH));

   assign w_push   = r_inflight;
   assign valid_o  = (r_occ != '0);
   assign w_pop    = valid_o & ready_i;
   // On a simultaneous pop the tail moves down by one before the write.
   assign w_wr_idx = w_pop ? (r_occ - OW'(1)) : r_occ;

   assign data_o = r_buf[0];
   assign sop_o  = valid_o & (r_cnt == '0);
   assign eop_o  = valid_o & (r_cnt == CW'(PKT_LEN - 1));

   always_comb begin
      w_buf_nxt = r_buf;
      if (w_pop) begin
         for (int i = 0; i < BUF_DEPTH - 1; i++) w_buf_nxt[i] = r_buf[i+1];
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
         if (w_push && (OW'(i) == w_wr_idx)) w_buf_nxt[i] = fifo_q_i;
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_buf      <= '0;
         r_occ      <= '0;
         r_inflight <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_buf      <= w_buf_nxt;
         r_inflight <= fifo_rdreq_o;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
         if (w_pop) begin
            r_cnt <= (r_cnt == CW'(PKT_LEN - 1)) ? '0 : r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//   Directed bench for fifo_stream_reader with a behavioural normal-mode FIFO
//   in front of it and a scoreboard on the stream side (data order, sop/eop
//   against a beat count, and the outstanding-word bound).
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

   localparam int DW    = 8;
   localparam int DEPTH = 3;
   localparam int PLEN  = 4;

   logic          clk_i = 1'b0;
   logic          arstn_i;
   logic          en_i;
   logic [DW-1:0] fifo_q = '0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rdreq_o;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;
   logic          sop_o;
   logic          eop_o;

   int n_cmp = 0;
   int n_mis = 0;

   fifo_stream_reader #(.DWIDTH(DW), .BUF_DEPTH(DEPTH), .PKT_LEN(PLEN)) dut (
      .clk_i        (clk_i),
      .arstn_i      (arstn_i),
      .en_i         (en_i),
      .fifo_q_i     (fifo_q),
      .fifo_empty_i (fifo_empty),
      .fifo_rdreq_o (fifo_rdreq_o),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .sop_o        (sop_o),
      .eop_o        (eop_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Behavioural FIFO: q is valid the cycle after rdreq, empty is registered.
   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];
   logic          wr_en;
   logic [DW-1:0] wr_d;
   int            rd_total = 0;

   always @(posedge clk_i) begin
      if (!arstn_i) begin
         fq.delete();
         exp_q.delete();
         rd_total   <= 0;
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_rdreq_o) begin
            if (fq.size() == 0) chk("rd_on_empty", 1, 0);
            else fifo_q <= fq.pop_front();
            rd_total <= rd_total + 1;
         end
         if (wr_en) begin
            fq.push_back(wr_d);
            exp_q.push_back(wr_d);
         end
         fifo_empty <= (fq.size() == 0);
      end
   end

   // Stream monitor: mid-cycle, a valid&&ready seen here completes at the
   // next rising edge.
   int beat = 0;
   int pops = 0;

   always @(negedge clk_i) begin
      if (!arstn_i) begin
         beat <= 0;
         pops <= 0;
      end else begin
         chk("occ_bound", 32'((rd_total - pops) <= DEPTH), 1);
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else begin
               chk("sb_data", data_o, exp_q[0]);
               void'(exp_q.pop_front());
            end
            chk("sb_sop", sop_o, beat == 0);
            chk("sb_eop", eop_o, beat == PLEN - 1);
            beat <= (beat == PLEN - 1) ? 0 : beat + 1;
            pops <= pops + 1;
         end
      end
   end

   initial begin
      int r0, nv, ns, ne, first, last, dcnt;
      arstn_i = 1'b0; en_i = 1'b0; ready_i = 1'b0; wr_en = 1'b0; wr_d = '0;
      #2;
      chk("rst_valid", valid_o, 0);
      chk("rst_rdreq", fifo_rdreq_o, 0);
      chk("rst_data",  data_o, 0);
      chk("rst_sop",   sop_o, 0);
      chk("rst_eop",   eop_o, 0);
      repeat (2) tick();
      arstn_i = 1'b1;
      repeat (3) tick();
      chk("idle_valid", valid_o, 0);
      chk("idle_rdreq", fifo_rdreq_o, 0);

      // Single word, ready low
      en_i = 1'b1;
      r0 = rd_total;
      wr_en = 1'b1; wr_d = 8'hA5; tick(); wr_en = 1'b0;
      chk("sw_rdreq_c0", fifo_rdreq_o, 1);
      tick();
      chk("sw_rdreq_c1", fifo_rdreq_o, 0);
      chk("sw_valid_c1", valid_o, 0);
      tick();
      chk("sw_valid_c2", valid_o, 1);
      chk("sw_data",     data_o, 8'hA5);
      chk("sw_sop",      sop_o, 1);
      chk("sw_eop",      eop_o, 0);
      repeat (3) begin
         tick();
         chk("sw_hold_valid", valid_o, 1);
         chk("sw_hold_data",  data_o, 8'hA5);
         chk("sw_hold_sop",   sop_o, 1);
      end
      chk("sw_pulses", rd_total - r0, 1);
      ready_i = 1'b1; tick(); ready_i = 1'b0;
      chk("sw_drained", valid_o, 0);

      // Reset mid-cycle while a word is presented
      wr_en = 1'b1; wr_d = 8'h11; tick(); wr_en = 1'b0;
      repeat (2) tick();
      chk("rt_pre_valid", valid_o, 1);
      #2 arstn_i = 1'b0;
      #1;
      chk("rt_valid", valid_o, 0);
      chk("rt_rdreq", fifo_rdreq_o, 0);
      chk("rt_sop",   sop_o, 0);
      chk("rt_eop",   eop_o, 0);
      chk("rt_data",  data_o, 0);
      repeat (2) tick();
      arstn_i = 1'b1;
      repeat (3) tick();
      chk("rt_idle_valid", valid_o, 0);
      chk("rt_idle_rdreq", fifo_rdreq_o, 0);

      // Streaming 16 words with ready high
      ready_i = 1'b1;
      first = -1; last = -1; nv = 0; ns = 0; ne = 0;
      for (int i = 0; i < 30; i++) begin
         wr_en = (i < 16);
         wr_d  = 8'(i);
         tick();
         if (valid_o) begin
            if (first < 0) first = i;
            last = i;
            nv++;
            ns += int'(sop_o);
            ne += int'(eop_o);
         end
      end
      wr_en = 1'b0;
      chk("st_first", first, 2);
      chk("st_last",  last, 17);
      chk("st_beats", nv, 16);
      chk("st_sops",  ns, 4);
      chk("st_eops",  ne, 4);

      // Backpressure: 8 words queued, ready low
      ready_i = 1'b0; en_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_d = 8'(8'h20 + i); tick();
      end
      wr_en = 1'b0;
      r0 = rd_total;
      en_i = 1'b1;
      repeat (10) tick();
      chk("bp_pulses", rd_total - r0, 3);
      chk("bp_valid",  valid_o, 1);
      chk("bp_data",   data_o, 8'h20);
      ready_i = 1'b1;
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         if (valid_o) nv++;
         tick();
      end
      chk("bp_beats", nv, 8);
      tick();
      chk("bp_done", valid_o, 0);

      // en_i gating with a full buffer
      ready_i = 1'b0; en_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_d = 8'(8'h30 + i); tick();
      end
      wr_en = 1'b0;
      repeat (6) tick();
      chk("en_full_valid", valid_o, 1);
      en_i = 1'b0; ready_i = 1'b1;
      #1;
      chk("en_rdreq_off", fifo_rdreq_o, 0);
      nv = 0;
      for (int i = 0; i < 5; i++) begin
         if (valid_o) nv++;
         chk("en_rdreq_held", fifo_rdreq_o, 0);
         tick();
      end
      chk("en_drained", nv, 3);
      chk("en_valid_low", valid_o, 0);
      en_i = 1'b1;
      #1;
      chk("en_resume", fifo_rdreq_o, 1);
      repeat (10) tick();
      chk("en_all_out", exp_q.size(), 0);

      // Random ready / writes / enable against the scoreboard
      dcnt = 0;
      for (int c = 0; c < 10000; c++) begin
         ready_i = ($urandom_range(0, 3) != 0);
         wr_en   = ($urandom_range(0, 1) == 1);
         wr_d    = 8'(dcnt);
         if (wr_en) dcnt++;
         en_i    = ($urandom_range(0, 9) != 0);
         tick();
      end
      wr_en = 1'b0; en_i = 1'b1; ready_i = 1'b1;
      for (int k = 0; k < 4000 && exp_q.size() != 0; k++) tick();
      repeat (3) tick();
      chk("rand_exp_empty",  exp_q.size(), 0);
      chk("rand_fifo_empty", fq.size(), 0);
      chk("rand_valid_low",  valid_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
